mod_data_mem_loader: RTL and testbench
======================================

# mod_data_mem_loader

Board-side writer for the data memory: lets the user enter 32-bit words from 16 slide switches and push buttons and write them into data memory through its second port before, or between, processor runs. It sits in the FPGA top level beside the seven-segment readout path, which reads data memory through the same port. While loading, it holds the MIPS processor. Writes are stretched so the slow, divided-clock memory always captures them.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable `clk` cycles required before a button is accepted.
- WRITE_HOLD_CYCLES, 15001: number of `clk` cycles `mem_write` stays high; must be at least one divided-clock period.
- ADDR_WIDTH, 10: width of the word address counter.

Ports:
- clk  in  1  board clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears every register.
- load_mode  in  1  level; 1 means the loader owns memory port 2 and holds the processor.
- sw_data  in  16  switch value.
- btn_latch_lo, btn_latch_hi  in  1 each  copy `sw_data` into bits [15:0] / [31:16] of the staged word.
- btn_commit  in  1  write the staged word to memory.
- btn_next, btn_prev  in  1 each  address +1 / −1.
- mem_address  out  32  word address, zero-extended from ADDR_WIDTH.
- mem_write_data  out  32  registered copy of the staged word, stable throughout a write.
- mem_write  out  1  write strobe.
- proc_hold  out  1  drives the processor hold input.
- staged_word  out  32  current staged value, for display.
- write_count  out  16  completed writes; saturates at 16'hFFFF.
- busy  out  1  high while in WRITE.

## Operation
- Each button input goes through a 2-flop synchronizer and then a debounce counter. One single-cycle event fires on each accepted rising edge. Holding a button produces no repeat events.
- FSM states: IDLE, EDIT, WRITE, DRAIN.
  - IDLE: `proc_hold` = 0 and all events are ignored. `load_mode` = 1 → EDIT.
  - EDIT: `proc_hold` = 1 and events are acted on.
    - `load_mode` = 0 → IDLE.
    - commit event → WRITE.
  - WRITE: `mem_write` = 1 and a counter runs WRITE_HOLD_CYCLES. At expiry:
    - `write_count` increments.
    - Next state is EDIT, or DRAIN if `load_mode` fell during the write.
  - DRAIN: one cycle with `proc_hold` = 1 and `mem_write` = 0, then → IDLE.
- Same-cycle event priority: commit > latch_hi > latch_lo > next > prev. Only the highest-priority event is acted on; the others are dropped.
- Events arriving in IDLE, WRITE or DRAIN are discarded.
- The address wraps modulo 2^ADDR_WIDTH in both directions, so 0 − 1 = 2^ADDR_WIDTH − 1.
- `mem_address` and `mem_write_data` do not change while `busy` = 1.

## Timing
- Reset values:
  - state IDLE.
  - `mem_address`, `mem_write_data`, `staged_word`, `write_count` = 0.
  - `mem_write`, `proc_hold`, `busy` = 0.
- Button latency: from the first `clk` edge a pressed button is sampled to its event takes 2 + DEBOUNCE_CYCLES cycles.
- Commit event in cycle N: `mem_write` and `busy` are high in cycles N+1 … N+WRITE_HOLD_CYCLES. `write_count` updates in cycle N+WRITE_HOLD_CYCLES+1.
- `proc_hold` rises on the cycle after EDIT is entered. It falls the cycle after IDLE is re-entered.
- Reset asserted mid-write: `mem_write` falls immediately. The contents of the target memory word are then undefined and are not checked.

## Configuration
- LOADER_AUTO_INCR_EN defined: each completed write increments `mem_address` (with wrap) in the same cycle as `write_count`.
- LOADER_AUTO_INCR_EN undefined: the address changes only on next/prev events.

## Structure
- Shared defines include `loader_defines.v`, holding:
  - FSM state encodings (2-bit).
  - Default parameter values.
  - Event priority index constants.
- One sub-module, `mod_button_debounce` (synchronizer, debounce, edge pulse), instantiated five times.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and WRITE_HOLD_CYCLES = 8.
1. `load_mode` = 1; latch_lo with `sw_data` = 16'h5678; latch_hi with `sw_data` = 16'h1234 → `staged_word` = 32'h12345678; `proc_hold` = 1.
2. Commit at address 0 → `mem_write` high exactly 8 cycles with `mem_address` = 0 and `mem_write_data` = 32'h12345678; `write_count` = 1.
3. Bouncing `btn_next` (toggling every 2 cycles for 10 cycles, then steady high) → exactly one increment; `mem_address` = 1.
4. prev at address 0 → `mem_address` = 1023.
5. Drop `load_mode` during WRITE → the write completes with all 8 cycles, DRAIN lasts 1 cycle, and `proc_hold` then falls.
6. Assert reset at cycle 3 of WRITE → `mem_write` = 0 immediately; all outputs return to their reset values.

Source files
------------

// File: rtl/mod_data_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// mod_data_mem_loader_pkg
// Shared definitions for the data-memory loader:
//   - FSM state encodings (2-bit)
//   - default parameter values
//   - event priority index constants and the decoded-operation type
//   - select_op(): picks the single highest-priority event of a cycle
// -----------------------------------------------------------------------------
package mod_data_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EDIT  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DRAIN = 2'd3
  } loader_state_e;

  localparam int DEF_DEBOUNCE_CYCLES   = 250000;
  localparam int DEF_WRITE_HOLD_CYCLES = 15001;
  localparam int DEF_ADDR_WIDTH        = 10;

  // Event vector bit positions; a lower index means a higher priority.
  localparam int NUM_EVENTS  = 5;
  localparam int EV_COMMIT   = 0;
  localparam int EV_LATCH_HI = 1;
  localparam int EV_LATCH_LO = 2;
  localparam int EV_NEXT     = 3;
  localparam int EV_PREV     = 4;

  typedef enum logic [2:0] {
    OP_NONE     = 3'd0,
    OP_COMMIT   = 3'd1,
    OP_LATCH_HI = 3'd2,
    OP_LATCH_LO = 3'd3,
    OP_NEXT     = 3'd4,
    OP_PREV     = 3'd5
  } loader_op_e;

  // Only the highest-priority event survives; the rest are dropped.
  function automatic loader_op_e select_op(input logic [NUM_EVENTS-1:0] ev);
    loader_op_e op;
    if (ev[EV_COMMIT])        op = OP_COMMIT;
    else if (ev[EV_LATCH_HI]) op = OP_LATCH_HI;
    else if (ev[EV_LATCH_LO]) op = OP_LATCH_LO;
    else if (ev[EV_NEXT])     op = OP_NEXT;
    else if (ev[EV_PREV])     op = OP_PREV;
    else                      op = OP_NONE;
    return op;
  endfunction

endpackage

// File: rtl/mod_data_mem_loader_debounce.sv
// -----------------------------------------------------------------------------
// mod_button_debounce
// One push button: 2-flop synchronizer, stable-level debounce counter and a
// single-cycle pulse on each accepted rising edge (no auto-repeat).
// Ports:
//   clk      in  board clock
//   reset    in  asynchronous, active-high
//   btn_i    in  raw button level
//   pulse_o  out one-cycle event per accepted press
// -----------------------------------------------------------------------------
module mod_button_debounce
  import mod_data_mem_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounce: the synchronized level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles before it is adopted.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      pulse_d = sync2_q;
      cnt_d   = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer, debounce state and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/mod_data_mem_loader.sv
// -----------------------------------------------------------------------------
// mod_data_mem_loader
// Board-side writer for data memory port 2. Words are staged from 16 switches
// (low/high halves), written with a strobe stretched to WRITE_HOLD_CYCLES so
// the divided-clock memory captures it, and the processor is held meanwhile.
// Ports:
//   clk, reset (async, active-high)
//   load_mode                 loader owns port 2 / holds processor
//   sw_data[15:0]             switch value
//   btn_latch_lo/_hi, btn_commit, btn_next, btn_prev   raw buttons
//   mem_address[31:0], mem_write_data[31:0], mem_write   memory port 2
//   proc_hold, staged_word[31:0], write_count[15:0], busy
// Configuration macro: LOADER_AUTO_INCR_EN -- when defined, each completed
// write also advances the address (with wrap).
// -----------------------------------------------------------------------------
module mod_data_mem_loader
  import mod_data_mem_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int WRITE_HOLD_CYCLES = DEF_WRITE_HOLD_CYCLES,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_mode,
  input  logic [15:0] sw_data,
  input  logic        btn_latch_lo,
  input  logic        btn_latch_hi,
  input  logic        btn_commit,
  input  logic        btn_next,
  input  logic        btn_prev,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        proc_hold,
  output logic [31:0] staged_word,
  output logic [15:0] write_count,
  output logic        busy
);

  localparam int HW = (WRITE_HOLD_CYCLES > 1) ? $clog2(WRITE_HOLD_CYCLES) : 1;

  loader_state_e           state_q, state_d;
  logic [NUM_EVENTS-1:0]   btn_raw_s, ev_s;
  loader_op_e              op_s;
  logic                    hold_done_s;
  logic [HW-1:0]           hold_cnt_q, hold_cnt_d;
  logic                    lm_fell_q, lm_fell_d;
  logic [31:0]             staged_q, staged_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             wcount_q, wcount_d;
  logic                    mem_write_q, mem_write_d;
  logic                    busy_q, busy_d;
  logic                    proc_hold_q, proc_hold_d;

  assign btn_raw_s[EV_COMMIT]   = btn_commit;
  assign btn_raw_s[EV_LATCH_HI] = btn_latch_hi;
  assign btn_raw_s[EV_LATCH_LO] = btn_latch_lo;
  assign btn_raw_s[EV_NEXT]     = btn_next;
  assign btn_raw_s[EV_PREV]     = btn_prev;

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_btn
    mod_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_raw_s[g]),
      .pulse_o(ev_s[g])
    );
  end

  // Events count only in EDIT while load_mode is still held; otherwise dropped.
  assign op_s = (state_q == ST_EDIT && load_mode) ? select_op(ev_s) : OP_NONE;

  assign hold_done_s = (state_q == ST_WRITE) && (hold_cnt_q == HW'(WRITE_HOLD_CYCLES - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_mode) state_d = ST_EDIT;
        else           state_d = ST_IDLE;
      end
      ST_EDIT: begin
        if (!load_mode)             state_d = ST_IDLE;
        else if (op_s == OP_COMMIT) state_d = ST_WRITE;
        else                        state_d = ST_EDIT;
      end
      ST_WRITE: begin
        // A write is never cut short; a dropped load_mode only redirects the exit.
        if (!hold_done_s)                 state_d = ST_WRITE;
        else if (lm_fell_q || !load_mode) state_d = ST_DRAIN;
        else                              state_d = ST_EDIT;
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output decode; strobes follow the next state so they are registered
  // yet line up with the WRITE cycles, while proc_hold lags the state by one.
  always_comb begin
    mem_write_d = (state_d == ST_WRITE);
    busy_d      = (state_d == ST_WRITE);
    proc_hold_d = (state_q != ST_IDLE);
  end

  // Datapath next-state: staging, address, write hold counter, write count.
  always_comb begin
    staged_d   = staged_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    wcount_d   = wcount_q;
    hold_cnt_d = hold_cnt_q;
    lm_fell_d  = lm_fell_q;
    case (op_s)
      OP_COMMIT: begin
        wdata_d    = staged_q;
        hold_cnt_d = {HW{1'b0}};
        lm_fell_d  = 1'b0;
      end
      OP_LATCH_HI: staged_d[31:16] = sw_data;
      OP_LATCH_LO: staged_d[15:0]  = sw_data;
      OP_NEXT:     addr_d = addr_q + ADDR_WIDTH'(1);
      OP_PREV:     addr_d = addr_q - ADDR_WIDTH'(1);
      OP_NONE:     staged_d = staged_q;
      default:     staged_d = staged_q;
    endcase
    if (state_q == ST_WRITE) begin
      if (!load_mode) lm_fell_d = 1'b1;
      else            lm_fell_d = lm_fell_q;
      if (hold_done_s) begin
        hold_cnt_d = {HW{1'b0}};
        if (wcount_q != 16'hFFFF) wcount_d = wcount_q + 16'd1;
        else                      wcount_d = wcount_q;
`ifdef LOADER_AUTO_INCR_EN
        addr_d = addr_q + ADDR_WIDTH'(1);
`else
        addr_d = addr_q;
`endif
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end else begin
      lm_fell_d = lm_fell_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staged_q    <= 32'd0;
      wdata_q     <= 32'd0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wcount_q    <= 16'd0;
      hold_cnt_q  <= {HW{1'b0}};
      lm_fell_q   <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      proc_hold_q <= 1'b0;
    end else begin
      staged_q    <= staged_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      wcount_q    <= wcount_d;
      hold_cnt_q  <= hold_cnt_d;
      lm_fell_q   <= lm_fell_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      proc_hold_q <= proc_hold_d;
    end
  end

  assign mem_address    = 32'(addr_q);
  assign mem_write_data = wdata_q;
  assign mem_write      = mem_write_q;
  assign busy           = busy_q;
  assign proc_hold      = proc_hold_q;
  assign staged_word    = staged_q;
  assign write_count    = wcount_q;

endmodule

// File: tb/tb_mod_data_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mod_data_mem_loader
// Self-checking bench: directed scenarios plus randomized button presses,
// compared against a transaction-level model of the loader.
// -----------------------------------------------------------------------------
module tb_mod_data_mem_loader;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int AW   = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_mode;
  logic [15:0] sw_data;
  logic        btn_latch_lo, btn_latch_hi, btn_commit, btn_next, btn_prev;
  logic [31:0] mem_address, mem_write_data, staged_word;
  logic        mem_write, proc_hold, busy;
  logic [15:0] write_count;

  int checks   = 0;
  int failures = 0;

  // model state
  bit          lm;
  logic [31:0] exp_staged, exp_wdata;
  int          exp_addr, exp_count, exp_wr_addr;

  // write-pulse monitor
  int          n_pulses = 0;
  int          wr_len = 0, bz_len = 0;
  logic [31:0] wr_addr, wr_data;
  bit          wr_stable;
  bit          mw_prev = 1'b0, bz_prev = 1'b0;

  mod_data_mem_loader #(
    .DEBOUNCE_CYCLES  (DEB),
    .WRITE_HOLD_CYCLES(HOLD),
    .ADDR_WIDTH       (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_mode     (load_mode),
    .sw_data       (sw_data),
    .btn_latch_lo  (btn_latch_lo),
    .btn_latch_hi  (btn_latch_hi),
    .btn_commit    (btn_commit),
    .btn_next      (btn_next),
    .btn_prev      (btn_prev),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_write     (mem_write),
    .proc_hold     (proc_hold),
    .staged_word   (staged_word),
    .write_count   (write_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Measure each mem_write / busy pulse and address/data stability during it.
  always @(negedge clk) begin
    if (mem_write && !mw_prev) begin
      n_pulses  = n_pulses + 1;
      wr_len    = 1;
      wr_addr   = mem_address;
      wr_data   = mem_write_data;
      wr_stable = 1'b1;
    end else if (mem_write) begin
      wr_len = wr_len + 1;
      if (mem_address !== wr_addr || mem_write_data !== wr_data) wr_stable = 1'b0;
    end
    if (busy && !bz_prev) bz_len = 1;
    else if (busy)        bz_len = bz_len + 1;
    mw_prev = mem_write;
    bz_prev = busy;
  end

  task automatic model_reset();
    lm = 1'b0; exp_staged = 32'd0; exp_wdata = 32'd0;
    exp_addr = 0; exp_count = 0; exp_wr_addr = 0;
  endtask

  // Transaction-level effect of one (possibly multi-button) press.
  task automatic model_apply(input logic [4:0] m, input logic [15:0] sw, output bit wrote);
    wrote = 1'b0;
    if (!lm || m == 5'd0) return;
    if (m[0]) begin
      exp_wdata   = exp_staged;
      exp_wr_addr = exp_addr;
      if (exp_count < 65535) exp_count = exp_count + 1;
`ifdef LOADER_AUTO_INCR_EN
      exp_addr = (exp_addr + 1) % 1024;
`endif
      wrote = 1'b1;
    end else if (m[1]) exp_staged = {sw, exp_staged[15:0]};
    else if (m[2])     exp_staged = {exp_staged[31:16], sw};
    else if (m[3])     exp_addr = (exp_addr + 1) % 1024;
    else               exp_addr = (exp_addr + 1023) % 1024;
  endtask

  task automatic check_state(input string tag);
    chk_eq({tag, ".staged"}, staged_word, exp_staged);
    chk_eq({tag, ".addr"},   mem_address, 32'(exp_addr));
    chk_eq({tag, ".count"},  32'(write_count), 32'(exp_count));
    chk_eq({tag, ".wdata"},  mem_write_data, exp_wdata);
    chk_eq({tag, ".hold"},   32'(proc_hold), 32'(lm));
    chk_eq({tag, ".busy"},   32'(busy), 32'd0);
  endtask

  task automatic check_pulse(input string tag);
    chk_eq({tag, ".wr_len"}, 32'(wr_len), 32'(HOLD));
    chk_eq({tag, ".bz_len"}, 32'(bz_len), 32'(HOLD));
    chk_eq({tag, ".wr_stable"}, 32'(wr_stable), 32'd1);
    chk_eq({tag, ".wr_addr"}, wr_addr, 32'(exp_wr_addr));
    chk_eq({tag, ".wr_data"}, wr_data, exp_wdata);
  endtask

  // mask bits: 0 commit, 1 latch_hi, 2 latch_lo, 3 next, 4 prev
  task automatic press(input string tag, input logic [4:0] m, input logic [15:0] sw);
    int  p0;
    bit  wrote;
    p0 = n_pulses;
    model_apply(m, sw, wrote);
    sw_data = sw;
    {btn_prev, btn_next, btn_latch_lo, btn_latch_hi, btn_commit} = m;
    repeat (10) @(negedge clk);
    {btn_prev, btn_next, btn_latch_lo, btn_latch_hi, btn_commit} = 5'd0;
    repeat (16) @(negedge clk);
    check_state(tag);
    chk_eq({tag, ".pulses"}, 32'(n_pulses - p0), 32'(wrote));
    if (wrote) check_pulse(tag);
  endtask

  task automatic wait_write(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (mem_write) ok = 1'b1;
    end
    chk_eq({tag, ".wait_write"}, 32'(ok), 32'd1);
  endtask

  task automatic set_mode(input bit v);
    load_mode = v;
    lm = v;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [4:0]  m;
    logic [15:0] sw;
    reset = 1'b1; load_mode = 1'b0; sw_data = 16'd0;
    {btn_prev, btn_next, btn_latch_lo, btn_latch_hi, btn_commit} = 5'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    chk_eq("reset.mem_write", 32'(mem_write), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: stage 32'h12345678
    set_mode(1'b1);
    press("latch_lo", 5'b00100, 16'h5678);
    press("latch_hi", 5'b00010, 16'h1234);
    chk_eq("t1.staged", staged_word, 32'h12345678);
    chk_eq("t1.hold", 32'(proc_hold), 32'd1);

    // 2: commit at address 0
    press("commit0", 5'b00001, 16'hFFFF);
    chk_eq("t2.count", 32'(write_count), 32'd1);

    // 3: bouncing next gives one increment
    sw_data = 16'd0;
    btn_next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_next = ~btn_next;
      repeat (2) @(negedge clk);
    end
    btn_next = 1'b1;
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    repeat (16) @(negedge clk);
    exp_addr = (exp_addr + 1) % 1024;
    chk_eq("t3.bounce_addr", mem_address, 32'(exp_addr));

    // 4: prev wraps from 0 to 1023
    press("prev1", 5'b10000, 16'd0);
    press("prev0", 5'b10000, 16'd0);
    chk_eq("t4.wrap", mem_address, 32'd1023);
    press("next_wrap", 5'b01000, 16'd0);

    // randomized presses, including simultaneous buttons and idle periods
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) set_mode(~lm);
      if ($urandom_range(0, 9) < 7) m = 5'(1 << $urandom_range(0, 4));
      else                          m = 5'($urandom_range(1, 31));
      sw = 16'($urandom);
      press("rand", m, sw);
    end

    // 5: drop load_mode during WRITE
    if (!lm) set_mode(1'b1);
    press("t5.stage", 5'b00100, 16'hBEEF);
    begin
      bit wrote;
      int p0;
      p0 = n_pulses;
      model_apply(5'b00001, 16'd0, wrote);
      btn_commit = 1'b1;
      wait_write("t5");
      load_mode = 1'b0;
      lm = 1'b0;
      for (int i = 0; i < 20 && mem_write; i++) @(negedge clk);
      chk_eq("t5.drain_mw", 32'(mem_write), 32'd0);
      chk_eq("t5.drain_hold", 32'(proc_hold), 32'd1);
      @(negedge clk);
      chk_eq("t5.idle_hold", 32'(proc_hold), 32'd1);
      @(negedge clk);
      chk_eq("t5.hold_fell", 32'(proc_hold), 32'd0);
      btn_commit = 1'b0;
      repeat (10) @(negedge clk);
      check_pulse("t5");
      chk_eq("t5.pulses", 32'(n_pulses - p0), 32'd1);
      check_state("t5");
    end

    // events in IDLE are ignored
    press("idle_next", 5'b01000, 16'd0);
    press("idle_commit", 5'b00001, 16'd0);

    // 6: reset at cycle 3 of WRITE
    set_mode(1'b1);
    btn_commit = 1'b1;
    wait_write("t6");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_eq("t6.mw_now", 32'(mem_write), 32'd0);
    btn_commit = 1'b0;
    load_mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("t6");
    chk_eq("t6.mem_write", 32'(mem_write), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_state("t6.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
